draw_scheduler: RTL and testbench
=================================

// Module: draw_scheduler
// PURPOSE
//  Sequences the shared square-drawing datapath across NUM_OBJ game objects once per frame.
//  Started by the game control FSM from its draw state; returns finish_drawing when done.
//  Erase pass: repaints background over every object drawn last frame.
//  Draw pass: draws every object valid this frame.
//  One request at a time over a req/done handshake with the datapath.
// PARAMETERS
//  NUM_OBJ  4  number of object slots (>=2)
//  IDX_W    2  object index width; must equal $clog2(NUM_OBJ)
// PORTS
//  clock           in   1        system clock, all logic on posedge
//  reset           in   1        synchronous, active-low
//  start_frame     in   1        start one erase+draw sequence; sampled only in S_IDLE
//  obj_valid       in   NUM_OBJ  per-object active mask; snapshotted at accepted start_frame
//  draw_done       in   1        1-cycle pulse from datapath: current request finished
//  obj_idx         out  IDX_W    object selected for current request
//  erase           out  1        1 = paint background colour, 0 = paint object colour
//  draw_req        out  1        1-cycle request pulse to datapath
//  clear_req       out  1        1-cycle full-screen clear request (see CONFIGURATION)
//  busy            out  1        high in every state except S_IDLE
//  finish_drawing  out  1        1-cycle pulse on sequence completion
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=S_IDLE, idx=0, cur_mask=0, prev_mask=0, first_frame=1.
//   All outputs 0. Applies mid-operation too: any outstanding request is abandoned.
//  Outputs are Moore-decoded from state; obj_idx=idx in all states, 0 in S_IDLE.
//  States / transitions:
//   S_IDLE: start_frame=1 -> cur_mask<=obj_valid, idx<=0, go S_ERASE_ISSUE (or S_CLEAR_ISSUE).
//   S_ERASE_ISSUE, prev_mask[idx]=1: draw_req=1, erase=1; go S_ERASE_WAIT.
//   S_ERASE_ISSUE, prev_mask[idx]=0: no request; advance.
//   S_ERASE_WAIT: hold idx; on draw_done, advance.
//   Erase advance: idx==NUM_OBJ-1 -> idx<=0, S_DRAW_ISSUE; else idx+1, S_ERASE_ISSUE.
//   S_DRAW_ISSUE / S_DRAW_WAIT: same pattern using cur_mask, erase=0.
//   Draw advance at last idx -> S_DONE.
//   S_DONE: finish_drawing=1; prev_mask<=cur_mask; first_frame<=0; go S_IDLE.
//  Timing:
//   Skipped slot costs 1 cycle. Issued slot costs 1 cycle + wait until draw_done.
//   Empty masks: finish_drawing is high exactly 2*NUM_OBJ+1 cycles after the start_frame sample.
//  Boundaries:
//   start_frame while busy: ignored.
//   obj_valid changes mid-frame: ignored until next accepted start_frame.
//   draw_done outside a WAIT state, incl. same cycle as draw_req: ignored.
//   No request while previous one is outstanding.
//   idx never exceeds NUM_OBJ-1; no wrap beyond the last slot.
// CONFIGURATION
//  CLEAR_SCREEN_EN defined:
//   - Accepted start_frame with first_frame=1 goes to S_CLEAR_ISSUE.
//   - S_CLEAR_ISSUE: clear_req=1 for 1 cycle, then S_CLEAR_WAIT.
//   - S_CLEAR_WAIT: on draw_done -> S_ERASE_ISSUE.
//   - Later frames skip the clear states.
//  CLEAR_SCREEN_EN undefined:
//   - No clear states exist; clear_req tied 0.
// TESTING (NUM_OBJ=4; datapath model returns draw_done 3 cycles after each req)
//  1 Reset, start_frame with obj_valid=4'b0000 -> no draw_req; finish_drawing pulse 9 cycles later; busy high 9 cycles.
//  2 First frame, obj_valid=4'b0101 -> no erase reqs; draw reqs idx 0 then 2, erase=0; one finish pulse.
//  3 Next frame, obj_valid=4'b0011 -> erase reqs idx 0,2 (erase=1), then draw reqs idx 0,1 (erase=0), in that order.
//  4 Mid-frame: toggle obj_valid, pulse start_frame, inject stray draw_done in an ISSUE state -> sequence and req count identical to test 3.
//  5 reset=0 during S_DRAW_WAIT -> next cycle all outputs 0, busy=0; next frame has no erase reqs.
//  6 CLEAR_SCREEN_EN defined -> clear_req precedes first erase/draw req in frame 1 only; undefined -> clear_req always 0.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
//   Bundles the frame-control and datapath handshake signals of draw_scheduler.
//
//   Handshake: draw_req (or clear_req) is a one-cycle request carrying obj_idx
//   and erase. The scheduler issues nothing further until the datapath answers
//   with a one-cycle draw_done. A draw_done arriving while no request is
//   outstanding, including the cycle the request itself is raised, is ignored.
//
//   Signals
//     start_frame     control -> sched  start one erase+draw sequence
//     obj_valid       control -> sched  per-object active mask
//     draw_done       datapath -> sched request finished (1-cycle pulse)
//     obj_idx         sched -> datapath object selected for current request
//     erase           sched -> datapath 1 = background colour, 0 = object colour
//     draw_req        sched -> datapath 1-cycle draw request
//     clear_req       sched -> datapath 1-cycle full-screen clear request
//     busy            sched -> control  high whenever not idle
//     finish_drawing  sched -> control  1-cycle pulse at sequence completion
//
//   Modports
//     master : the environment (game control FSM + square datapath)
//     slave  : the scheduler
// -----------------------------------------------------------------------------
interface draw_scheduler_if #(
   parameter int NUM_OBJ = 4,
   parameter int IDX_W   = 2
);
   logic               start_frame;
   logic [NUM_OBJ-1:0] obj_valid;
   logic               draw_done;
   logic [IDX_W-1:0]   obj_idx;
   logic               erase;
   logic               draw_req;
   logic               clear_req;
   logic               busy;
   logic               finish_drawing;

   modport master (
      output start_frame, obj_valid, draw_done,
      input  obj_idx, erase, draw_req, clear_req, busy, finish_drawing
   );

   modport slave (
      input  start_frame, obj_valid, draw_done,
      output obj_idx, erase, draw_req, clear_req, busy, finish_drawing
   );
endinterface

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
//   Sequences the shared square-drawing datapath over NUM_OBJ object slots once
//   per frame. An erase pass repaints background over every object drawn in the
//   previous frame, then a draw pass paints every object valid in this frame.
//   Exactly one datapath request is in flight at a time.
//
//   Optional feature (macro CLEAR_SCREEN_EN):
//     defined   : the first frame after reset begins with one full-screen
//                 clear request (clear_req) before the erase pass.
//     undefined : no clear states; clear_req stays 0.
//
//   Ports
//     clock      in   system clock, all logic on posedge
//     reset      in   synchronous, active-low
//     bus        slave modport of draw_scheduler_if (see that file)
//     state_dbg  out  current FSM state, for observation only
//
//   Parameters
//     NUM_OBJ    number of object slots (>= 2)
//     IDX_W      object index width; must equal $clog2(NUM_OBJ)
// -----------------------------------------------------------------------------
module draw_scheduler #(
   parameter int NUM_OBJ = 4,
   parameter int IDX_W   = 2
) (
   input  logic               clock,
   input  logic               reset,
   draw_scheduler_if.slave    bus,
   output logic [3:0]         state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_ERASE_ISSUE = 4'd1,
      S_ERASE_WAIT  = 4'd2,
      S_DRAW_ISSUE  = 4'd3,
      S_DRAW_WAIT   = 4'd4,
`ifdef CLEAR_SCREEN_EN
      S_CLEAR_ISSUE = 4'd6,
      S_CLEAR_WAIT  = 4'd7,
`endif
      S_DONE        = 4'd5
   } state_t;

   // Registered copy of every output, updated together with the state so the
   // outputs always match the state they belong to without any output logic.
   typedef struct packed {
      logic [IDX_W-1:0] obj_idx;
      logic             erase;
      logic             draw_req;
      logic             clear_req;
      logic             busy;
      logic             finish_drawing;
   } out_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [NUM_OBJ-1:0] cur_mask;     // objects drawn in this frame
   logic [NUM_OBJ-1:0] prev_mask;    // objects drawn in the previous frame
   logic               first_frame;  // no frame completed since reset
   out_t               outs;

   // Slot advance shared by both passes: step to the next slot, or at the last
   // slot return to slot 0 and move on to the following pass.
   logic [IDX_W-1:0]   adv_idx;
   state_t             erase_adv_state;
   state_t             draw_adv_state;

   assign adv_idx         = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
   assign erase_adv_state = (idx == LAST_IDX) ? S_DRAW_ISSUE : S_ERASE_ISSUE;
   assign draw_adv_state  = (idx == LAST_IDX) ? S_DONE       : S_DRAW_ISSUE;

   // Output pattern for a given state. An ISSUE state raises draw_req only
   // when its slot is set in the pass's mask; otherwise the slot is skipped.
   function automatic out_t decode(
      input state_t             st,
      input logic [IDX_W-1:0]   i,
      input logic [NUM_OBJ-1:0] cm,
      input logic [NUM_OBJ-1:0] pm
   );
      out_t o;
      o         = '0;
      o.busy    = (st != S_IDLE);
      o.obj_idx = (st == S_IDLE) ? '0 : i;
      case (st)
         S_ERASE_ISSUE: begin
            o.erase    = 1'b1;
            o.draw_req = pm[i];
         end
         S_ERASE_WAIT:  o.erase          = 1'b1;
         S_DRAW_ISSUE:  o.draw_req       = cm[i];
         S_DONE:        o.finish_drawing = 1'b1;
`ifdef CLEAR_SCREEN_EN
         S_CLEAR_ISSUE: o.clear_req      = 1'b1;
`endif
         default: ;
      endcase
      return o;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         // Also abandons any outstanding request mid-frame.
         state       <= S_IDLE;
         idx         <= '0;
         cur_mask    <= '0;
         prev_mask   <= '0;
         first_frame <= 1'b1;
         outs        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start_frame) begin
                  // The mask is frozen here; later obj_valid changes wait for
                  // the next frame.
                  cur_mask <= bus.obj_valid;
                  idx      <= '0;
`ifdef CLEAR_SCREEN_EN
                  if (first_frame) begin
                     state <= S_CLEAR_ISSUE;
                     outs  <= decode(S_CLEAR_ISSUE, '0, bus.obj_valid, prev_mask);
                  end else begin
                     state <= S_ERASE_ISSUE;
                     outs  <= decode(S_ERASE_ISSUE, '0, bus.obj_valid, prev_mask);
                  end
`else
                  state <= S_ERASE_ISSUE;
                  outs  <= decode(S_ERASE_ISSUE, '0, bus.obj_valid, prev_mask);
`endif
               end
            end

`ifdef CLEAR_SCREEN_EN
            S_CLEAR_ISSUE: begin
               state <= S_CLEAR_WAIT;
               outs  <= decode(S_CLEAR_WAIT, idx, cur_mask, prev_mask);
            end

            S_CLEAR_WAIT: begin
               if (bus.draw_done) begin
                  state <= S_ERASE_ISSUE;
                  idx   <= '0;
                  outs  <= decode(S_ERASE_ISSUE, '0, cur_mask, prev_mask);
               end
            end
`endif

            S_ERASE_ISSUE: begin
               // draw_done is not looked at here, so a pulse arriving in the
               // same cycle as the request cannot complete it.
               if (prev_mask[idx]) begin
                  state <= S_ERASE_WAIT;
                  outs  <= decode(S_ERASE_WAIT, idx, cur_mask, prev_mask);
               end else begin
                  state <= erase_adv_state;
                  idx   <= adv_idx;
                  outs  <= decode(erase_adv_state, adv_idx, cur_mask, prev_mask);
               end
            end

            S_ERASE_WAIT: begin
               if (bus.draw_done) begin
                  state <= erase_adv_state;
                  idx   <= adv_idx;
                  outs  <= decode(erase_adv_state, adv_idx, cur_mask, prev_mask);
               end
            end

            S_DRAW_ISSUE: begin
               if (cur_mask[idx]) begin
                  state <= S_DRAW_WAIT;
                  outs  <= decode(S_DRAW_WAIT, idx, cur_mask, prev_mask);
               end else begin
                  state <= draw_adv_state;
                  idx   <= adv_idx;
                  outs  <= decode(draw_adv_state, adv_idx, cur_mask, prev_mask);
               end
            end

            S_DRAW_WAIT: begin
               if (bus.draw_done) begin
                  state <= draw_adv_state;
                  idx   <= adv_idx;
                  outs  <= decode(draw_adv_state, adv_idx, cur_mask, prev_mask);
               end
            end

            S_DONE: begin
               // This frame's objects become the ones to erase next frame.
               prev_mask   <= cur_mask;
               first_frame <= 1'b0;
               state       <= S_IDLE;
               idx         <= '0;
               outs        <= '0;
            end

            default: begin
               state <= S_IDLE;
               idx   <= '0;
               outs  <= '0;
            end
         endcase
      end
   end

   assign bus.obj_idx        = outs.obj_idx;
   assign bus.erase          = outs.erase;
   assign bus.draw_req       = outs.draw_req;
   assign bus.clear_req      = outs.clear_req;  // never set without CLEAR_SCREEN_EN
   assign bus.busy           = outs.busy;
   assign bus.finish_drawing = outs.finish_drawing;
   assign state_dbg          = state;

endmodule

// File: tb/tb_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_scheduler
//   Self-checking bench for draw_scheduler (NUM_OBJ=4). A datapath model
//   answers every request with draw_done three cycles later. The reference
//   model builds, per frame, the ordered list of requests the frame must
//   produce and the frame length from the slot-cost rules; observed requests
//   are popped from that list as they appear.
// -----------------------------------------------------------------------------
module tb_draw_scheduler;
   localparam int NUM_OBJ = 4;
   localparam int IDX_W   = 2;
`ifdef CLEAR_SCREEN_EN
   localparam bit CLEAR_BUILD = 1'b1;
`else
   localparam bit CLEAR_BUILD = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   draw_scheduler_if #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) bus ();
   logic [3:0] state_dbg;

   draw_scheduler #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   logic dp_done    = 1'b0;
   logic stray_done = 1'b0;
   assign bus.draw_done = dp_done | stray_done;

   // ---------------- scoreboard state ----------------
   logic [31:0]        exp_q[$];
   logic [NUM_OBJ-1:0] prev_model  = '0;
   bit                 first_model = 1'b1;
   int                 exp_cycles;
   int                 exp_reqs;
   int                 n_cmp = 0;
   int                 n_err = 0;
   int                 dp_cnt = 0;
   int                 req_count = 0;
   int                 fin_count = 0;
   bit                 fin_now = 1'b0;
   bit                 saw_draw_req = 1'b0;
   bit                 noise_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic c, input logic e, input logic [IDX_W-1:0] i);
      return (32'(c) << (IDX_W + 1)) | (32'(e) << IDX_W) | 32'(i);
   endfunction

   // Expected request list and frame length for one accepted start_frame.
   task automatic model_frame(input logic [NUM_OBJ-1:0] v);
      bit do_clear;
      do_clear = CLEAR_BUILD && first_model;
      if (do_clear) exp_q.push_back(enc(1'b1, 1'b0, '0));
      for (int i = 0; i < NUM_OBJ; i++)
         if (prev_model[i]) exp_q.push_back(enc(1'b0, 1'b1, IDX_W'(i)));
      for (int i = 0; i < NUM_OBJ; i++)
         if (v[i]) exp_q.push_back(enc(1'b0, 1'b0, IDX_W'(i)));
      exp_reqs   = $countones(prev_model) + $countones(v) + (do_clear ? 1 : 0);
      // every slot costs one cycle, each request adds three wait cycles,
      // the clear costs four, the done state one
      exp_cycles = 2 * NUM_OBJ + 1 + 3 * ($countones(prev_model) + $countones(v))
                   + (do_clear ? 4 : 0);
      prev_model  = v;
      first_model = 1'b0;
   endtask

   // ---------------- per-cycle driver / monitor / datapath ----------------
   task automatic tick();
      logic req;
      int   cnt_before;
      @(negedge clock);
      req     = bus.draw_req | bus.clear_req;
      fin_now = reset && bus.finish_drawing;
      if (reset && req) begin
         check("no_overlap", 32'(dp_cnt != 0), 32'd0);
         check("req_seq", enc(bus.clear_req, bus.erase, bus.obj_idx),
               (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFF);
         req_count++;
         if (bus.draw_req && !bus.erase) saw_draw_req = 1'b1;
      end
      if (fin_now) fin_count++;
      stray_done = 1'b0;
      if (!reset) begin
         dp_cnt  = 0;
         dp_done = 1'b0;
         bus.start_frame = 1'b0;
      end else begin
         cnt_before = dp_cnt;
         dp_done    = 1'b0;
         if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) dp_done = 1'b1;
         end
         if (req) dp_cnt = 3;
         if (noise_en && !fin_now) begin
            bus.start_frame = ($urandom_range(0, 2) == 0);
            bus.obj_valid   = NUM_OBJ'($urandom);
            // stray pulses only while nothing is outstanding
            stray_done      = (cnt_before == 0) && ($urandom_range(0, 1) == 1);
         end else begin
            bus.start_frame = 1'b0;
         end
      end
   endtask

   task automatic run_frame(input logic [NUM_OBJ-1:0] v, input bit noisy);
      int cycles;
      bit done;
      model_frame(v);
      req_count = 0;
      fin_count = 0;
      bus.obj_valid   = v;
      bus.start_frame = 1'b1;
      cycles = 0;
      done   = 1'b0;
      while (!done && cycles < 400) begin
         tick();
         cycles++;
         noise_en = noisy;
         check("busy_in_frame", 32'(bus.busy), 32'd1);
         if (fin_now) done = 1'b1;
      end
      noise_en = 1'b0;
      check("finish_seen", 32'(done), 32'd1);
      check("frame_cycles", 32'(cycles), 32'(exp_cycles));
      check("req_count", 32'(req_count), 32'(exp_reqs));
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      tick();
      check("busy_after", 32'(bus.busy), 32'd0);
      check("idx_idle", 32'(bus.obj_idx), 32'd0);
      check("finish_once", 32'(fin_count), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_draw_req"}, 32'(bus.draw_req), 32'd0);
      check({tag, "_clear_req"}, 32'(bus.clear_req), 32'd0);
      check({tag, "_erase"}, 32'(bus.erase), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_finish"}, 32'(bus.finish_drawing), 32'd0);
      check({tag, "_obj_idx"}, 32'(bus.obj_idx), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cycles;
      bus.start_frame = 1'b0;
      bus.obj_valid   = '0;

      repeat (3) tick();
      check_outputs_zero("reset");
      reset = 1'b1;
      repeat (2) tick();

      run_frame(4'b0000, 1'b0);   // empty masks
      run_frame(4'b0101, 1'b0);   // first real frame: draws only
      run_frame(4'b0011, 1'b0);   // erase 0,2 then draw 0,1
      run_frame(4'b0101, 1'b0);
      run_frame(4'b0011, 1'b0 | 1'b1);  // same frame with mid-frame noise

      // reset while waiting on a draw request
      model_frame(4'b1010);
      saw_draw_req    = 1'b0;
      bus.obj_valid   = 4'b1010;
      bus.start_frame = 1'b1;
      cycles = 0;
      while (!saw_draw_req && cycles < 400) begin
         tick();
         cycles++;
      end
      check("reached_draw", 32'(saw_draw_req), 32'd1);
      tick();
      check("wait_busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      tick();
      check_outputs_zero("midreset");
      reset = 1'b1;
      exp_q.delete();
      prev_model  = '0;
      first_model = 1'b1;
      tick();
      run_frame(4'b1111, 1'b0);   // no erase requests after reset

      for (int k = 0; k < 10; k++)
         run_frame(NUM_OBJ'($urandom), ($urandom_range(0, 1) == 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
